// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's fetch/LSU ports, the arbiter and the single-port memory.
// Handshake: a requester raises *_req with stable fields and holds it until the matching
// one-cycle *_ack pulse; the memory samples mem_addr/mem_wen/mem_wdata at posedge and
// returns mem_rdata one cycle after the address is presented.
interface mem_arbiter_if #(
  parameter int WORD_LEN = 32
);
  logic                i_req;
  logic [WORD_LEN-1:0] i_addr;
  logic                i_ack;
  logic [WORD_LEN-1:0] i_rdata;
  logic                d_req;
  logic                d_wen;
  logic [WORD_LEN-1:0] d_addr;
  logic [WORD_LEN-1:0] d_wmask;
  logic [WORD_LEN-1:0] d_wdata;
  logic                d_ack;
  logic [WORD_LEN-1:0] d_rdata;
  logic [WORD_LEN-1:0] mem_addr;
  logic                mem_wen;
  logic [WORD_LEN-1:0] mem_wdata;
  logic [WORD_LEN-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_wen, d_addr, d_wmask, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_wen, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wen, d_addr, d_wmask, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_wen, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one synchronous-read memory: data priority with a fetch
// starvation guard, and partial-mask stores turned into read-modify-write.
module mem_arbiter #(
  parameter int WORD_LEN     = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  mem_arbiter_if.slave                         bus,
  output logic [2:0]                           dbg_state,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]    dbg_starve
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]       LIMIT = SW'(STARVE_LIMIT);
  localparam logic [WORD_LEN-1:0] ONES  = '1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] IRD    = 3'd1;
  localparam logic [2:0] DRD    = 3'd2;
  localparam logic [2:0] RMW_WR = 3'd3;
  localparam logic [2:0] WACK   = 3'd4;

  logic [2:0]          state, state_nx;
  logic [SW-1:0]       starve;
  logic [WORD_LEN-1:0] lat_addr, lat_wmask, lat_wdata, lat_rdata;
  logic                d_grant, i_grant, full_mask, zero_mask;
  logic [WORD_LEN-1:0] merged;

  assign dbg_state  = state;
  assign dbg_starve = starve;

  always_comb begin
    full_mask = (bus.d_wmask == ONES);
    zero_mask = (bus.d_wmask == '0);
    d_grant   = (state == IDLE) && bus.d_req && !(bus.i_req && (starve == LIMIT));
    i_grant   = (state == IDLE) && !d_grant && bus.i_req;
    merged    = (bus.mem_rdata & ~lat_wmask) | (lat_wdata & lat_wmask);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (d_grant) begin
          if (!bus.d_wen)                 state_nx = DRD;
          else if (full_mask || zero_mask) state_nx = WACK;
          else                             state_nx = RMW_WR;
        end else if (i_grant) begin
          state_nx = IRD;
        end
      end
      RMW_WR:  state_nx = WACK;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes and acks are gated by rst_n so nothing escapes while reset is held.
  always_comb begin
    bus.mem_addr = (state == IDLE) ? (d_grant ? bus.d_addr : bus.i_addr) : lat_addr;
    bus.mem_wen  = rst_n && ((d_grant && bus.d_wen && full_mask) || (state == RMW_WR));
    bus.mem_wdata = '0;
    if (bus.mem_wen) bus.mem_wdata = (state == RMW_WR) ? merged : bus.d_wdata;
    bus.i_ack   = rst_n && (state == IRD);
    bus.i_rdata = (state == IRD) ? bus.mem_rdata : '0;
    bus.d_ack   = rst_n && ((state == DRD) || (state == WACK));
    case (state)
      DRD, RMW_WR: bus.d_rdata = bus.mem_rdata;
      WACK:        bus.d_rdata = lat_rdata;
      default:     bus.d_rdata = '0;
    endcase
  end

  // lat_rdata holds the pre-store word so a partial store reports it with its ack;
  // full and empty-mask stores leave it at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      starve    <= '0;
      lat_addr  <= '0;
      lat_wmask <= '0;
      lat_wdata <= '0;
      lat_rdata <= '0;
    end else begin
      state <= state_nx;
      if (!bus.i_req || i_grant)           starve <= '0;
      else if (d_grant && starve != LIMIT) starve <= starve + 1'b1;
      if (d_grant) begin
        lat_addr  <= bus.d_addr;
        lat_wmask <= bus.d_wmask;
        lat_wdata <= bus.d_wdata;
        lat_rdata <= '0;
      end else if (i_grant) begin
        lat_addr  <= bus.i_addr;
        lat_wmask <= '0;
        lat_wdata <= '0;
        lat_rdata <= '0;
      end else if (state == RMW_WR) begin
        lat_rdata <= bus.mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of single transactions against a behavioural
// memory, plus hand sequences for reset, starvation guard and reset during RMW.
module tb_mem_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] dbg_state;
  logic [2:0] dbg_starve;

  mem_arbiter_if #(.WORD_LEN(32)) bus ();

  mem_arbiter #(.WORD_LEN(32), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_state  (dbg_state),
    .dbg_starve (dbg_starve)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory: registered read, read-before-write.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    bus.mem_rdata <= mem[bus.mem_addr[11:2]];
    if (bus.mem_wen) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] i_exp_q[$];
  logic [31:0] d_exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every ack pops the oldest expectation for its port.
  always @(negedge clk) begin
    if (bus.i_ack) begin
      if (i_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_i_ack: got ack with data %h expected no ack", bus.i_rdata);
      end else chk("i_rdata", bus.i_rdata, i_exp_q.pop_front());
    end
    if (bus.d_ack) begin
      if (d_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_d_ack: got ack with data %h expected no ack", bus.d_rdata);
      end else chk("d_rdata", bus.d_rdata, d_exp_q.pop_front());
    end
  end

  typedef struct {
    logic        is_d;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wmask;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wdata;
    int          exp_lat;
    int          exp_wens;
  } vec_t;

  task automatic run_txn(input vec_t v, input string tag);
    int cnt, wens;
    logic [31:0] wd;
    logic done;
    if (v.is_d) d_exp_q.push_back(v.exp_rdata);
    else        i_exp_q.push_back(v.exp_rdata);
    @(posedge clk); #1;
    if (v.is_d) begin
      bus.d_req = 1'b1; bus.d_wen = v.wen; bus.d_addr = v.addr;
      bus.d_wmask = v.wmask; bus.d_wdata = v.wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = v.addr;
    end
    cnt = 0; wens = 0; wd = '0; done = 1'b0;
    while (!done && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (bus.mem_wen) begin wens++; wd = bus.mem_wdata; end
      if (v.is_d ? bus.d_ack : bus.i_ack) done = 1'b1;
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    chk({tag, "_ack_seen"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, cnt - 1, v.exp_lat);
    chk({tag, "_wen_cycles"}, wens, v.exp_wens);
    if (v.exp_wens > 0) chk({tag, "_mem_wdata"}, wd, v.exp_wdata);
  endtask

  vec_t vecs[11];
  vec_t v;
  logic [31:0] r0, m, d, mg;
  logic [9:0]  got_order;
  int          nack, cyc;
  logic [2:0]  max_starve;

  initial begin
    //             is_d  wen   addr         wmask         wdata         exp_rdata     exp_wdata     lat wens
    vecs[0]  = '{1'b1, 1'b1, 32'h100, 32'hFFFFFFFF, 32'h00000013, 32'h0,        32'h00000013, 1, 1};
    vecs[1]  = '{1'b1, 1'b1, 32'h300, 32'hFFFFFFFF, 32'h11223344, 32'h0,        32'h11223344, 1, 1};
    vecs[2]  = '{1'b1, 1'b1, 32'h400, 32'hFFFFFFFF, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 1, 1};
    vecs[3]  = '{1'b0, 1'b0, 32'h100, 32'h0,        32'h0,        32'h00000013, 32'h0,        1, 0};
    vecs[4]  = '{1'b1, 1'b1, 32'h200, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1, 1};
    vecs[5]  = '{1'b1, 1'b0, 32'h200, 32'h0,        32'h0,        32'hDEADBEEF, 32'h0,        1, 0};
    vecs[6]  = '{1'b1, 1'b1, 32'h300, 32'h0000FF00, 32'h0000AA00, 32'h11223344, 32'h1122AA44, 2, 1};
    vecs[7]  = '{1'b1, 1'b0, 32'h300, 32'h0,        32'h0,        32'h1122AA44, 32'h0,        1, 0};
    vecs[8]  = '{1'b1, 1'b1, 32'h400, 32'h0,        32'h12345678, 32'h0,        32'h0,        1, 0};
    vecs[9]  = '{1'b1, 1'b0, 32'h400, 32'h0,        32'h0,        32'hCAFEF00D, 32'h0,        1, 0};
    vecs[10] = '{1'b0, 1'b0, 32'h300, 32'h0,        32'h0,        32'h1122AA44, 32'h0,        1, 0};

    // Reset held with a full-store grant condition present: nothing may escape.
    rst_n = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b1; bus.d_wen = 1'b1; bus.d_addr = 32'h40;
    bus.d_wmask = 32'hFFFFFFFF; bus.d_wdata = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
      chk("rst_d_ack", 32'(bus.d_ack), 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    end
    bus.d_req = 1'b0; bus.d_wen = 1'b0; bus.d_wmask = '0; bus.d_wdata = '0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_state", 32'(dbg_state), 32'd0);
    chk("post_rst_starve", 32'(dbg_starve), 32'd0);
    chk("post_rst_i_ack", 32'(bus.i_ack), 32'd0);

    for (int k = 0; k < 11; k++) run_txn(vecs[k], $sformatf("vec%0d", k));

    // Random masks: preload a word, store through a random mask, read it back.
    for (int k = 0; k < 6; k++) begin
      r0 = $urandom; d = $urandom;
      case (k)
        0:       m = 32'h0;
        1:       m = 32'hFFFFFFFF;
        default: m = $urandom;
      endcase
      mg = (r0 & ~m) | (d & m);
      v = '{1'b1, 1'b1, 32'h500 + 32'(k * 4), 32'hFFFFFFFF, r0, 32'h0, r0, 1, 1};
      run_txn(v, $sformatf("rnd%0d_pre", k));
      v.wmask = m; v.wdata = d; v.exp_wdata = mg;
      v.exp_lat   = (m == 32'h0 || m == 32'hFFFFFFFF) ? 1 : 2;
      v.exp_wens  = (m == 32'h0) ? 0 : 1;
      v.exp_rdata = (v.exp_lat == 2) ? r0 : 32'h0;
      run_txn(v, $sformatf("rnd%0d_st", k));
      v = '{1'b1, 1'b0, 32'h500 + 32'(k * 4), 32'h0, 32'h0, mg, 32'h0, 1, 0};
      run_txn(v, $sformatf("rnd%0d_ld", k));
    end

    // Starvation guard: both requests held continuously.
    for (int k = 0; k < 8; k++) d_exp_q.push_back(32'hDEADBEEF);
    for (int k = 0; k < 2; k++) i_exp_q.push_back(32'h00000013);
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    bus.d_req = 1'b1; bus.d_wen = 1'b0; bus.d_addr = 32'h200; bus.d_wmask = '0;
    nack = 0; cyc = 0; got_order = '0; max_starve = '0;
    while (nack < 10 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (dbg_starve > max_starve) max_starve = dbg_starve;
      if (bus.i_ack)      begin got_order[nack] = 1'b1; nack++; end
      else if (bus.d_ack) begin got_order[nack] = 1'b0; nack++; end
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    chk("starve_ack_count", nack, 10);
    chk("starve_grant_order", 32'(got_order), 32'b10_0001_0000);
    chk("starve_max", 32'(max_starve), 32'd4);

    // Reset during RMW_WR abandons the store.
    v = '{1'b1, 1'b1, 32'h600, 32'hFFFFFFFF, 32'h55555555, 32'h0, 32'h55555555, 1, 1};
    run_txn(v, "rmwrst_pre");
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_wen = 1'b1; bus.d_addr = 32'h600;
    bus.d_wmask = 32'h00FF00FF; bus.d_wdata = 32'hAAAAAAAA;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (dbg_state != 3'd3 && cyc < 10);
    chk("rmwrst_reached", 32'(dbg_state), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rmwrst_mem_wen", 32'(bus.mem_wen), 32'd0);
    chk("rmwrst_d_ack", 32'(bus.d_ack), 32'd0);
    @(negedge clk);
    bus.d_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rmwrst_state", 32'(dbg_state), 32'd0);
    chk("rmwrst_starve", 32'(dbg_starve), 32'd0);
    chk("rmwrst_no_ack", 32'(bus.d_ack), 32'd0);
    v = '{1'b1, 1'b0, 32'h600, 32'h0, 32'h0, 32'h55555555, 32'h0, 1, 0};
    run_txn(v, "rmwrst_ld");

    repeat (3) @(negedge clk);
    chk("i_queue_drained", i_exp_q.size(), 0);
    chk("d_queue_drained", d_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
